id_hazard_scoreboard: RTL and testbench
=======================================

// Module: id_hazard_scoreboard
// PURPOSE
//   Register scoreboard and stall generator for the 5-stage pipeline. Tracks destination
//   registers written by instructions that left ID but have not yet written back. Drives
//   the ID-stage stall (ID readygo = ~stall) on a RAW or WAW-overflow hazard.
//   Sits beside ID: issue events come from the ID->EX handshake, retire events from WB.
// PARAMETERS
//   NREG   32  architectural GPR count; r0 is hardwired zero and never tracked
//   CNT_W  2   per-register in-flight counter width; MAXCNT = 2**CNT_W-1
// PORTS
//   clk             in   1   clock
//   rst             in   1   synchronous, active-high reset
//   id_valid        in   1   ID holds a valid instruction
//   id_raddr1       in   5   ID source 1 (rj)
//   id_use1         in   1   source 1 is actually read
//   id_raddr2       in   5   ID source 2 (rk or rd)
//   id_use2         in   1   source 2 is actually read
//   id_waddr        in   5   ID destination
//   id_we           in   1   ID instruction writes the GPR file
//   id_fire         in   1   ID->EX transfer this cycle (ID validout & EX allowin)
//   wb_valid        in   1   WB holds a valid instruction
//   wb_we           in   1   WB writes the GPR file this cycle
//   wb_waddr        in   5   WB destination
//   flush           in   1   discard all in-flight tracking
//   stall           out  1   ID must not advance
//   pending_mask    out  32  bit r = cnt[r]!=0 (bit 0 always 0)
//   err_underflow   out  1   sticky: retire seen for a register whose cnt was 0
//   stall_cycles    out  32  perf counter (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: all cnt=0, stall=0, pending_mask=0, err_underflow=0, stall_cycles=0.
//   - issue  = id_fire & id_we & (id_waddr!=0); retire = wb_valid & wb_we & (wb_waddr!=0).
//   - Per reg r at posedge: issue-only -> cnt+1; retire-only -> cnt-1; both same r -> unchanged.
//   - Retire when cnt==0: cnt stays 0, err_underflow <= 1 (cleared only by rst).
//   - Issue when cnt==MAXCNT cannot occur: stall blocks it (below). Bench asserts this.
//   - stall (combinational, same cycle) = id_valid & (raw1 | raw2 | waw_full)
//       raw1 = id_use1 & id_raddr1!=0 & cnt[id_raddr1]!=0; raw2 likewise.
//       waw_full = id_we & id_waddr!=0 & cnt[id_waddr]==MAXCNT.
//   - Retire does not bypass: stall stays 1 in the cycle WB writes the register and
//     drops the following cycle, when the GPR file holds the new value.
//   - id_fire while stall=1 is a protocol violation (bench assertion); it is counted as issue anyway.
//   - flush: all cnt <= 0 next edge; same-cycle issue/retire ignored; err_underflow kept.
//   - rst mid-operation equals reset state regardless of in-flight events.
//   - stall never depends on id_fire (no combinational loop through pipeline handshake).
// CONFIGURATION
//   HAZARD_PERF_EN defined: stall_cycles +1 each cycle with stall=1 (id_valid implied),
//     saturates at 32'hFFFF_FFFF, cleared by rst only (not flush).
//   HAZARD_PERF_EN undefined: stall_cycles tied to 32'h0, no counter flops.
// STRUCTURE
//   Package hazard_pkg: REG_AW=5, NREG, CNT_W, MAXCNT, typedef cnt_t [CNT_W-1:0].
//   Sub-module sb_counter: one per register 1..NREG-1 (inc, dec, clr, cnt, full, underflow);
//   top holds decode of issue/retire addresses, stall mux, mask, sticky error, perf counter.
// TESTING
//   1 issue add.w r5 (cnt5=1), next ID reads rj=r5 -> stall=1; WB retires r5 at cycle t -> stall=1 at t, 0 at t+1.
//   2 issue writes to r0, ID reads r0 via both sources -> stall=0, pending_mask=0 throughout.
//   3 cnt7=1, same-cycle issue r7 and retire r7 -> cnt7 stays 1, pending_mask[7]=1.
//   4 three issues to r9 with no retire (cnt9=3) -> ID with id_we, id_waddr=9 gets stall=1; one retire -> stall=0 next cycle.
//   5 cnt3=0, retire r3 -> err_underflow=1 and stays 1 after flush; cnt3 remains 0.
//   6 pending r4,r6 then flush (or rst) -> pending_mask=0, stall=0 next cycle;
//     with HAZARD_PERF_EN, 5 stalled cycles -> stall_cycles=5, unchanged by flush.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared sizing for the ID-stage register scoreboard.
// Optional stall-cycle perf counter is enabled with HAZARD_PERF_EN.
package hazard_pkg;

    localparam int REG_AW = 5;
    localparam int NREG   = 32;
    localparam int CNT_W  = 2;
    localparam int MAXCNT = (1 << CNT_W) - 1;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight write counter for the hazard scoreboard.
// Counts issues minus retires; saturates at both ends.
module sb_counter
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_clr,
    output cnt_t o_cnt,
    output logic o_full,
    output logic o_underflow
);

    cnt_t r_cnt;
    logic w_empty;

    assign w_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == cnt_t'(MAXCNT));
    assign o_cnt   = r_cnt;

    // A flush swallows a same-cycle retire, so it cannot raise an underflow.
    assign o_underflow = i_dec & w_empty & ~i_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !o_full) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc && !w_empty) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage register scoreboard: RAW / WAW-overflow stall generation.
// Define HAZARD_PERF_EN to build the saturating stall-cycle counter.
module id_hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_raddr1,
    input  logic              i_id_use1,
    input  logic [REG_AW-1:0] i_id_raddr2,
    input  logic              i_id_use2,
    input  logic [REG_AW-1:0] i_id_waddr,
    input  logic              i_id_we,
    input  logic              i_id_fire,
    input  logic              i_wb_valid,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_waddr,
    input  logic              i_flush,
    output logic              o_stall,
    output logic [NREG-1:0]   o_pending_mask,
    output logic              o_err_underflow,
    output logic [31:0]       o_stall_cycles
);

    logic            w_issue;
    logic            w_retire;
    logic [NREG-1:0] w_pend;
    logic [NREG-1:0] w_full;
    logic [NREG-1:0] w_uf;
    logic            w_raw1;
    logic            w_raw2;
    logic            w_waw_full;
    logic            r_err;

    assign w_issue  = i_id_fire & i_id_we & (i_id_waddr != '0);
    assign w_retire = i_wb_valid & i_wb_we & (i_wb_waddr != '0);

    // r0 is hardwired zero and never tracked.
    assign w_pend[0] = 1'b0;
    assign w_full[0] = 1'b0;
    assign w_uf[0]   = 1'b0;

    genvar g;
    for (g = 1; g < NREG; g++) begin : g_reg
        cnt_t w_cnt;
        logic w_inc;
        logic w_dec;

        assign w_inc = w_issue & (i_id_waddr == REG_AW'(g));
        assign w_dec = w_retire & (i_wb_waddr == REG_AW'(g));

        sb_counter u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_inc),
            .i_dec       (w_dec),
            .i_clr       (i_flush),
            .o_cnt       (w_cnt),
            .o_full      (w_full[g]),
            .o_underflow (w_uf[g])
        );

        assign w_pend[g] = (w_cnt != '0);
    end

    // Counters update only at the edge, so a retiring write never bypasses.
    assign w_raw1     = i_id_use1 & (i_id_raddr1 != '0) & w_pend[i_id_raddr1];
    assign w_raw2     = i_id_use2 & (i_id_raddr2 != '0) & w_pend[i_id_raddr2];
    assign w_waw_full = i_id_we & (i_id_waddr != '0) & w_full[i_id_waddr];

    assign o_stall        = i_id_valid & (w_raw1 | w_raw2 | w_waw_full);
    assign o_pending_mask = w_pend;
    assign o_err_underflow = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|w_uf) begin
            r_err <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (o_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard.
// Expected stall_cycles follows HAZARD_PERF_EN.
module tb_id_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_raddr1;
    logic        id_use1;
    logic [4:0]  id_raddr2;
    logic        id_use2;
    logic [4:0]  id_waddr;
    logic        id_we;
    logic        id_fire;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic        flush;
    logic        stall;
    logic [31:0] pending_mask;
    logic        err_underflow;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sc   = 0;

    id_hazard_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .i_id_valid      (id_valid),
        .i_id_raddr1     (id_raddr1),
        .i_id_use1       (id_use1),
        .i_id_raddr2     (id_raddr2),
        .i_id_use2       (id_use2),
        .i_id_waddr      (id_waddr),
        .i_id_we         (id_we),
        .i_id_fire       (id_fire),
        .i_wb_valid      (wb_valid),
        .i_wb_we         (wb_we),
        .i_wb_waddr      (wb_waddr),
        .i_flush         (flush),
        .o_stall         (stall),
        .o_pending_mask  (pending_mask),
        .o_err_underflow (err_underflow),
        .o_stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake protocol: ID must never transfer while stalled.
    always @(negedge clk) begin
        if (!rst && id_fire && stall) begin
            n_errors++;
            $error("FAIL proto_fire_while_stall obs=1 exp=0");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; stalled says whether this cycle was expected to stall.
    task automatic tick(input bit stalled);
        @(posedge clk);
        if (rst) exp_sc = 0;
        else if (stalled) exp_sc++;
        #1;
    endtask

    task automatic chk_sc(input string tag);
`ifdef HAZARD_PERF_EN
        chk(tag, stall_cycles, 32'(exp_sc));
`else
        chk(tag, stall_cycles, 32'h0);
`endif
    endtask

    task automatic id_set(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] wa, input logic we,
                          input logic fire);
        id_valid  = v;
        id_raddr1 = r1;
        id_use1   = u1;
        id_raddr2 = r2;
        id_use2   = u2;
        id_waddr  = wa;
        id_we     = we;
        id_fire   = fire;
    endtask

    task automatic wb_set(input logic v, input logic we, input logic [4:0] wa);
        wb_valid = v;
        wb_we    = we;
        wb_waddr = wa;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        wb_set(0, 0, 0);
        tick(0);
        tick(0);
        mid();
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_mask", pending_mask, 0);
        chk("rst_err", {31'b0, err_underflow}, 0);
        chk("rst_sc", stall_cycles, 0);
        tick(0);
        rst = 1'b0;

        // 1: issue r5, dependent read stalls until the cycle after WB
        id_set(1, 0, 0, 0, 0, 5, 1, 1);
        mid();
        chk("t1_issue_stall", {31'b0, stall}, 0);
        tick(0);
        id_set(1, 5, 1, 0, 0, 10, 1, 0);
        mid();
        chk("t1_raw_stall", {31'b0, stall}, 1);
        chk("t1_mask", pending_mask, 32'h20);
        tick(1);
        mid();
        chk("t1_hold_stall", {31'b0, stall}, 1);
        tick(1);
        wb_set(1, 1, 5);
        mid();
        chk("t1_wb_cycle_stall", {31'b0, stall}, 1);
        tick(1);
        wb_set(0, 0, 0);
        mid();
        chk("t1_after_wb_stall", {31'b0, stall}, 0);
        chk("t1_mask_clear", pending_mask, 0);
        chk_sc("t1_sc");
        tick(0);

        // 2: writes to r0 are never tracked
        id_set(1, 0, 0, 0, 0, 0, 1, 1);
        tick(0);
        id_set(1, 0, 1, 0, 1, 0, 1, 0);
        mid();
        chk("t2_stall", {31'b0, stall}, 0);
        chk("t2_mask", pending_mask, 0);
        tick(0);

        // 3: simultaneous issue and retire of r7 keeps cnt7 at 1
        id_set(1, 0, 0, 0, 0, 7, 1, 1);
        tick(0);
        wb_set(1, 1, 7);
        mid();
        chk("t3_same_stall", {31'b0, stall}, 0);
        tick(0);
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        mid();
        chk("t3_mask", pending_mask, 32'h80);
        tick(0);
        wb_set(0, 0, 0);
        mid();
        chk("t3_mask_clear", pending_mask, 0);

        // 4: three writes to r9 fill the counter; a fourth must wait
        id_set(1, 0, 0, 0, 0, 9, 1, 1);
        tick(0);
        tick(0);
        tick(0);
        id_set(1, 0, 0, 0, 0, 9, 1, 0);
        mid();
        chk("t4_waw_stall", {31'b0, stall}, 1);
        chk("t4_mask", pending_mask, 32'h200);
        tick(1);
        wb_set(1, 1, 9);
        mid();
        chk("t4_wb_cycle_stall", {31'b0, stall}, 1);
        tick(1);
        wb_set(0, 0, 0);
        mid();
        chk("t4_after_wb_stall", {31'b0, stall}, 0);
        chk_sc("t4_sc");
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        wb_set(1, 1, 9);
        tick(0);
        tick(0);
        wb_set(0, 0, 0);
        mid();
        chk("t4_mask_clear", pending_mask, 0);
        chk("t4_no_err", {31'b0, err_underflow}, 0);

        // 5: retire of an idle register is sticky across flush
        wb_set(1, 1, 3);
        tick(0);
        wb_set(0, 0, 0);
        mid();
        chk("t5_err", {31'b0, err_underflow}, 1);
        chk("t5_mask", pending_mask, 0);
        flush = 1'b1;
        tick(0);
        flush = 1'b0;
        mid();
        chk("t5_err_after_flush", {31'b0, err_underflow}, 1);
        rst = 1'b1;
        tick(0);
        rst = 1'b0;
        mid();
        chk("t5_err_rst", {31'b0, err_underflow}, 0);
        chk("t5_sc_rst", stall_cycles, 0);

        // 6: pending r4, r6; five stalled cycles; flush clears tracking only
        id_set(1, 0, 0, 0, 0, 4, 1, 1);
        tick(0);
        id_set(1, 0, 0, 0, 0, 6, 1, 1);
        tick(0);
        id_set(1, 0, 0, 6, 1, 0, 0, 0);
        mid();
        chk("t6_mask", pending_mask, 32'h50);
        chk("t6_raw2_stall", {31'b0, stall}, 1);
        for (int i = 0; i < 5; i++) tick(1);
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        mid();
        chk_sc("t6_sc5");
        flush = 1'b1;
        id_set(1, 0, 0, 0, 0, 12, 1, 1);
        wb_set(1, 1, 4);
        tick(0);
        flush = 1'b0;
        id_set(1, 4, 1, 6, 1, 12, 1, 0);
        wb_set(0, 0, 0);
        mid();
        chk("t6_flush_mask", pending_mask, 0);
        chk("t6_flush_stall", {31'b0, stall}, 0);
        chk("t6_flush_err", {31'b0, err_underflow}, 0);
        chk_sc("t6_sc_after_flush");
        tick(0);

        // mid-operation reset drops in-flight state
        id_set(1, 0, 0, 0, 0, 8, 1, 1);
        tick(0);
        id_set(1, 8, 1, 0, 0, 0, 0, 0);
        mid();
        chk("rst2_pre_stall", {31'b0, stall}, 1);
        rst = 1'b1;
        wb_set(1, 1, 2);
        tick(1);
        rst = 1'b0;
        wb_set(0, 0, 0);
        mid();
        chk("rst2_mask", pending_mask, 0);
        chk("rst2_stall", {31'b0, stall}, 0);
        chk("rst2_err", {31'b0, err_underflow}, 0);
        chk("rst2_sc", stall_cycles, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
